// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake and divide-by-zero flag.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op input and two's-complement sign handling.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] dvs;

  logic             accept;
  logic             last_step;
  logic             divisor_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] mag_dividend;
  logic [WIDTH-1:0] mag_divisor;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q, neg_r;
`endif

  assign divisor_zero = (divisor == '0);
  assign last_step    = (count == CW'(WIDTH - 1));
  assign busy         = (state == CALC);
  assign done         = (state == DONE);

  // Operands enter the iteration as magnitudes; signs are reapplied when results load.
  always_comb begin
    mag_dividend = dividend;
    mag_divisor  = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_neg = signed_op & dividend[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    if (a_neg) mag_dividend = -dividend;
    if (b_neg) mag_divisor  = -divisor;
`endif
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          accept     = 1'b1;
          state_next = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The WIDTH+1-bit trial difference only ever leaves a WIDTH-bit remainder behind.
  always_comb begin
    rem_shift = {1'b0, part_rem, shift_q[WIDTH-1]} >> 0;
    rem_shift = {part_rem, shift_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs};
    q_bit     = ~rem_diff[WIDTH];
    rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    q_step    = {shift_q[WIDTH-2:0], q_bit};
    res_q     = q_step;
    res_r     = rem_step;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (neg_q) res_q = -q_step;
    if (neg_r) res_r = -rem_step;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      part_rem  <= '0;
      shift_q   <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (accept) begin
      count    <= '0;
      part_rem <= '0;
      shift_q  <= mag_dividend;
      dvs      <= mag_divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
`endif
      if (divisor_zero) begin
        quotient  <= '1;
        remainder <= dividend;
        div_zero  <= 1'b1;
      end
    end else if (state == CALC) begin
      count    <= count + 1'b1;
      part_rem <= rem_step;
      shift_q  <= q_step;
      if (last_step) begin
        quotient  <= res_q;
        remainder <= res_r;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model checked every cycle on a
// 32-bit instance, plus hand-computed directed vectors on 32-bit and 8-bit instances.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 32;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor  = '0;
  logic        sop      = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  logic        start8 = 1'b0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  int cyc       = 0;
  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op (sop),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .dividend  (a8),
    .divisor   (b8),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op (1'b0),
`endif
    .busy      (busy8),
    .done      (done8),
    .quotient  (q8),
    .remainder (r8),
    .div_zero  (dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Reference arithmetic: what a finished division must return.
  task automatic modelDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    dz = (b == 32'd0);
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endtask

  int          done_at   = -1;
  int          calc_from = -1;
  logic [31:0] exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;
  logic        exp_dz = 1'b0, pend_dz = 1'b0;
  logic        model_sop;

  // Timing model: a request seen while not mid-division completes WIDTH+1 cycles later
  // (or one cycle later for a zero divisor); outputs hold between completions.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q = '0; exp_r = '0; exp_dz = 1'b0;
      done_at = -1; calc_from = -1;
    end else if (cyc == done_at) begin
      exp_q = pend_q; exp_r = pend_r; exp_dz = pend_dz;
    end
    checkOutput("busy", busy, reset && cyc >= calc_from && cyc < done_at);
    checkOutput("done", done, reset && cyc == done_at);
    checkOutput("quotient", quotient, exp_q);
    checkOutput("remainder", remainder, exp_r);
    checkOutput("div_zero", div_zero, exp_dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    model_sop = sop;
`else
    model_sop = 1'b0;
`endif
    if (reset && start && !(cyc >= calc_from && cyc < done_at)) begin
      modelDiv(dividend, divisor, model_sop, pend_q, pend_r, pend_dz);
      if (divisor == 32'd0) begin
        done_at   = cyc + 1;
        calc_from = done_at;
      end else begin
        calc_from = cyc + 1;
        done_at   = cyc + W + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output int s_cyc);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b; sop = s;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int d_cyc);
    bit seen = 1'b0;
    d_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen  = 1'b1;
        d_cyc = cyc;
      end
    end
    if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic runDiv8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output int lat);
    int s_cyc;
    bit seen = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b; s_cyc = cyc;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; q = '0; r = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        seen = 1'b1; lat = cyc - s_cyc; q = q8; r = r8;
      end
    end
    if (!seen) checkOutput("done8_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] vec_a [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd12345678, 32'h8000_0000, 32'd99};
  logic [31:0] vec_b [6] = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'd1000, 32'd3, 32'd100};

  initial begin
    int s, d, s2, lat;
    logic [7:0] q, r;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] 7/2 latency and result");
    applyStimulus(32'd7, 32'd2, 1'b0, s);
    waitDone(40, d);
    checkOutput("lat_7_2", d - s, 33);
    checkOutput("q_7_2", quotient, 32'd3);
    checkOutput("r_7_2", remainder, 32'd1);
    checkOutput("dz_7_2", div_zero, 1'b0);

    $display("[TB] divide by zero");
    applyStimulus(32'd5, 32'd0, 1'b0, s);
    waitDone(5, d);
    checkOutput("lat_5_0", d - s, 1);
    checkOutput("q_5_0", quotient, 32'hFFFF_FFFF);
    checkOutput("r_5_0", remainder, 32'd5);
    checkOutput("dz_5_0", div_zero, 1'b1);

    $display("[TB] reset abort mid-calculation");
    applyStimulus(32'd100, 32'd7, 1'b0, s);
    repeat (8) @(posedge clk); #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_q", quotient, 32'd0);
    checkOutput("rst_r", remainder, 32'd0);
    checkOutput("rst_dz", div_zero, 1'b0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(32'd9, 32'd3, 1'b0, s);
    waitDone(40, d);
    checkOutput("lat_9_3", d - s, 33);
    checkOutput("q_9_3", quotient, 32'd3);
    checkOutput("r_9_3", remainder, 32'd0);

    $display("[TB] back-to-back accept in the done cycle");
    applyStimulus(32'hFFFF_FFFF, 32'h10, 1'b0, s);
    repeat (32) @(posedge clk); #1;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10; sop = 1'b0;
    s2 = cyc;
    @(negedge clk);
    checkOutput("b2b_done1", done, 1'b1);
    checkOutput("b2b_lat1", cyc - s, 33);
    checkOutput("b2b_q1", quotient, 32'h0FFF_FFFF);
    checkOutput("b2b_r1", remainder, 32'hF);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(40, d);
    checkOutput("b2b_lat2", d - s2, 33);
    checkOutput("b2b_q2", quotient, 32'd100);
    checkOutput("b2b_r2", remainder, 32'd0);

    $display("[TB] unsigned view of -7/2 bits");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, s);
    waitDone(40, d);
    checkOutput("q_u_m7_2", quotient, 32'h7FFF_FFFC);
    checkOutput("r_u_m7_2", remainder, 32'd1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    $display("[TB] signed operations");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, s);
    waitDone(40, d);
    checkOutput("lat_s_m7_2", d - s, 33);
    checkOutput("q_s_m7_2", quotient, 32'hFFFF_FFFD);
    checkOutput("r_s_m7_2", remainder, 32'hFFFF_FFFF);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, s);
    waitDone(40, d);
    checkOutput("q_s_7_m2", quotient, 32'hFFFF_FFFD);
    checkOutput("r_s_7_m2", remainder, 32'd1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, s);
    waitDone(40, d);
    checkOutput("q_s_min_m1", quotient, 32'h8000_0000);
    checkOutput("r_s_min_m1", remainder, 32'd0);
    checkOutput("dz_s_min_m1", div_zero, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, s);
    waitDone(5, d);
    checkOutput("q_s_div0", quotient, 32'hFFFF_FFFF);
    checkOutput("r_s_div0", remainder, 32'hFFFF_FFF9);
`endif

    $display("[TB] model-checked vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec_a[i], vec_b[i], 1'b0, s);
      waitDone(40, d);
    end

    $display("[TB] WIDTH=8 instance");
    runDiv8(8'd255, 8'd1, q, r, lat);
    checkOutput("w8_lat_255_1", lat, 9);
    checkOutput("w8_q_255_1", q, 8'd255);
    checkOutput("w8_r_255_1", r, 8'd0);
    runDiv8(8'd3, 8'd200, q, r, lat);
    checkOutput("w8_q_3_200", q, 8'd0);
    checkOutput("w8_r_3_200", r, 8'd3);
    runDiv8(8'd77, 8'd0, q, r, lat);
    checkOutput("w8_lat_div0", lat, 1);
    checkOutput("w8_q_div0", q, 8'hFF);
    checkOutput("w8_r_div0", r, 8'd77);
    checkOutput("w8_dz_div0", dz8, 1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
